// File: rtl/pipe_trace_buf.sv
// Commit-trace unit: circular buffer of retired instructions, shadow register file,
// PC-match / cycle-limit triggers and a post-trigger capture window that freezes in DONE.
module pipe_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            trig_pc_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [CW-1:0]   cyc_limit,
  input  logic [AW-1:0]   post_cnt,
  input  logic            cm_valid,
  input  logic [XLEN-1:0] cm_pc,
  input  logic [XLEN-1:0] cm_instr,
  input  logic            cm_we,
  input  logic [4:0]      cm_rd,
  input  logic [XLEN-1:0] cm_wdata,
  input  logic [AW-1:0]   rd_idx,
  input  logic [1:0]      rd_field,
  output logic [XLEN-1:0] rd_data,
  input  logic [4:0]      rf_sel,
  output logic [XLEN-1:0] rf_data,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic [AW-1:0]   trig_idx,
  output logic [CW-1:0]   cyc_cnt,
  output logic            halt_req
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [XLEN-1:0] rf  [32];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] post_lat;
  logic [AW-1:0] post_left;
  logic [AW-1:0] trig_phys;

  logic          capture;
  logic          pc_hit;
  logic          cyc_hit;
  logic          trigger;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_phys;
  logic          rd_hit;
  entry_t        rd_entry;
  logic [XLEN-1:0] rd_next;

  // arm always wins over any commit or trigger in the same cycle.
  assign capture = cm_valid & ~arm & ((state == S_ARMED) | (state == S_POST));
  assign pc_hit  = trig_pc_en & cm_valid & (cm_pc == trig_pc);
  assign cyc_hit = (cyc_limit != '0) & (cyc_cnt == cyc_limit);
  assign trigger = (state == S_ARMED) & ~arm & (pc_hit | cyc_hit);

  // count[AW-1:0] is 0 when full, which makes oldest == wr_ptr as required.
  assign oldest   = wr_ptr - count[AW-1:0];
  assign rd_phys  = oldest + rd_idx;
  assign rd_hit   = ({1'b0, rd_idx} < count);
  assign trig_idx = trig_phys - oldest;
  assign halt_req = (state == S_DONE);
  assign rf_data  = (rf_sel == 5'd0) ? '0 : rf[rf_sel];
  assign rd_entry = mem[rd_phys];

  always_comb begin
    // NOTE: default first so every path assigns rd_next and no latch is inferred.
    rd_next = '0;
    if (rd_hit) begin
      case (rd_field)
        2'd0:    rd_next = rd_entry.pc;
        2'd1:    rd_next = rd_entry.instr;
        2'd2:    rd_next = {{(XLEN-6){1'b0}}, rd_entry.we, rd_entry.rd};
        default: rd_next = rd_entry.wdata;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      post_lat  <= '0;
      post_left <= '0;
      trig_phys <= '0;
    end else if (arm) begin
      state     <= S_ARMED;
      wr_ptr    <= '0;
      count     <= '0;
      post_lat  <= post_cnt;
      post_left <= '0;
      trig_phys <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != FULL) count <= count + (AW+1)'(1);
      end
      case (state)
        S_ARMED: begin
          if (trigger) begin
            // A commit-less cycle-limit trigger points at the newest entry (or 0 if empty).
            if (cm_valid || count == '0) trig_phys <= wr_ptr;
            else                         trig_phys <= wr_ptr - AW'(1);
            post_left <= post_lat;
            state     <= (post_lat == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (capture) begin
            post_left <= post_left - AW'(1);
            if (post_left == AW'(1)) state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the trace array has no reset; count masks stale slots on readout.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= '{pc: cm_pc, instr: cm_instr, we: cm_we, rd: cm_rd, wdata: cm_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      cyc_cnt <= '0;
    end else begin
      rd_data <= rd_next;
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

  // Shadow register file tracks architectural state regardless of capture state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (cm_valid && cm_we && cm_rd != 5'd0) begin
      rf[cm_rd] <= cm_wdata;
    end
  end

endmodule

// File: tb/tb_pipe_trace_buf.sv
// Directed bench for pipe_trace_buf with DEPTH=8; each task drives one scenario and checks inline.
module tb_pipe_trace_buf;
  localparam int XLEN = 32, DEPTH = 8, AW = 3, CW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            arm = 1'b0;
  logic            trig_pc_en = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic [CW-1:0]   cyc_limit = '0;
  logic [AW-1:0]   post_cnt = '0;
  logic            cm_valid = 1'b0;
  logic [XLEN-1:0] cm_pc = '0, cm_instr = '0, cm_wdata = '0;
  logic            cm_we = 1'b0;
  logic [4:0]      cm_rd = '0;
  logic [AW-1:0]   rd_idx = '0;
  logic [1:0]      rd_field = '0;
  logic [XLEN-1:0] rd_data;
  logic [4:0]      rf_sel = '0;
  logic [XLEN-1:0] rf_data;
  logic [1:0]      state;
  logic [AW:0]     count;
  logic [AW-1:0]   trig_idx;
  logic [CW-1:0]   cyc_cnt;
  logic            halt_req;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .cyc_limit(cyc_limit), .post_cnt(post_cnt), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_instr(cm_instr), .cm_we(cm_we), .cm_rd(cm_rd), .cm_wdata(cm_wdata),
    .rd_idx(rd_idx), .rd_field(rd_field), .rd_data(rd_data), .rf_sel(rf_sel),
    .rf_data(rf_data), .state(state), .count(count), .trig_idx(trig_idx),
    .cyc_cnt(cyc_cnt), .halt_req(halt_req)
  );

  always #5 clk = ~clk;

  task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                        input logic [31:0] wdata);
    cm_valid = 1'b1; cm_pc = pc; cm_instr = pc + 32'h100; cm_we = we; cm_rd = rd; cm_wdata = wdata;
    @(posedge clk); #1;
    cm_valid = 1'b0; cm_we = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] idx, input logic [1:0] fld, output logic [31:0] val);
    rd_idx = idx; rd_field = fld;
    @(posedge clk); #1;
    val = rd_data;
  endtask

  task automatic test_reset();
    #1;
    n_checks += 6;
    if (state !== 2'd0)   begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    if (count !== '0)     begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    if (trig_idx !== '0)  begin n_fail++; $display("FAIL reset_trig_idx got %0d want 0", trig_idx); end
    if (cyc_cnt !== '0)   begin n_fail++; $display("FAIL reset_cyc_cnt got %0d want 0", cyc_cnt); end
    if (rd_data !== '0)   begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    if (halt_req !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", halt_req); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) commit(32'(i * 4), 1'b1, 5'd5, 32'h11);
    rf_sel = 5'd5; #1;
    n_checks += 3;
    if (count !== '0)        begin n_fail++; $display("FAIL idle_count got %0d want 0", count); end
    if (rf_data !== 32'h11)  begin n_fail++; $display("FAIL idle_rf5 got %h want 00000011", rf_data); end
    if (state !== 2'd0)      begin n_fail++; $display("FAIL idle_state got %0d want 0", state); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    trig_pc_en = 1'b0; cyc_limit = '0; post_cnt = '0;
    do_arm();
    n_checks += 2;
    if (state !== 2'd1) begin n_fail++; $display("FAIL wrap_armed got %0d want 1", state); end
    if (count !== '0)   begin n_fail++; $display("FAIL wrap_armcount got %0d want 0", count); end
    for (int i = 0; i < 12; i++) commit(32'(i * 4), 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
    n_checks += 1;
    if (count !== 4'd8) begin n_fail++; $display("FAIL wrap_count got %0d want 8", count); end
    read(3'd0, 2'd0, v); n_checks++;
    if (v !== 32'h10)        begin n_fail++; $display("FAIL wrap_idx0_pc got %h want 00000010", v); end
    read(3'd7, 2'd0, v); n_checks++;
    if (v !== 32'h2C)        begin n_fail++; $display("FAIL wrap_idx7_pc got %h want 0000002c", v); end
    read(3'd0, 2'd1, v); n_checks++;
    if (v !== 32'h110)       begin n_fail++; $display("FAIL wrap_idx0_instr got %h want 00000110", v); end
    read(3'd0, 2'd2, v); n_checks++;
    if (v !== 32'h25)        begin n_fail++; $display("FAIL wrap_idx0_werd got %h want 00000025", v); end
    read(3'd3, 2'd3, v); n_checks++;
    if (v !== 32'hA000_0007) begin n_fail++; $display("FAIL wrap_idx3_wdata got %h want a0000007", v); end
    rf_sel = 5'd12; #1; n_checks++;
    if (rf_data !== 32'hA000_000B) begin n_fail++; $display("FAIL wrap_rf12 got %h want a000000b", rf_data); end
  endtask

  task automatic test_pc_trigger();
    logic [31:0] v;
    trig_pc_en = 1'b1; trig_pc = 32'h14; post_cnt = 3'd2;
    do_arm();
    for (int i = 0; i < 9; i++) begin
      commit(32'(i * 4), 1'b0, 5'd0, 32'h0);
      if (i == 5) begin
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL pctrig_post got %0d want 2", state); end
      end
      if (i == 6) begin
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL pctrig_post2 got %0d want 2", state); end
      end
      if (i == 7) begin
        n_checks++;
        if (state !== 2'd3) begin n_fail++; $display("FAIL pctrig_done got %0d want 3", state); end
      end
    end
    n_checks += 4;
    if (state !== 2'd3)    begin n_fail++; $display("FAIL pctrig_state got %0d want 3", state); end
    if (count !== 4'd8)    begin n_fail++; $display("FAIL pctrig_count got %0d want 8", count); end
    if (trig_idx !== 3'd5) begin n_fail++; $display("FAIL pctrig_idx got %0d want 5", trig_idx); end
    if (halt_req !== 1'b1) begin n_fail++; $display("FAIL pctrig_halt got %b want 1", halt_req); end
    read(3'd5, 2'd0, v); n_checks++;
    if (v !== 32'h14) begin n_fail++; $display("FAIL pctrig_trigpc got %h want 00000014", v); end
    read(3'd7, 2'd0, v); n_checks++;
    if (v !== 32'h1C) begin n_fail++; $display("FAIL pctrig_newest got %h want 0000001c", v); end
  endtask

  task automatic test_arm_override();
    logic [31:0] v;
    arm = 1'b1;
    commit(32'h14, 1'b0, 5'd0, 32'h0);
    arm = 1'b0;
    n_checks += 2;
    if (state !== 2'd1) begin n_fail++; $display("FAIL armov_state got %0d want 1", state); end
    if (count !== '0)   begin n_fail++; $display("FAIL armov_count got %0d want 0", count); end
    commit(32'h40, 1'b0, 5'd0, 32'h0);
    read(3'd0, 2'd0, v);
    n_checks += 2;
    if (count !== 4'd1) begin n_fail++; $display("FAIL armov_count1 got %0d want 1", count); end
    if (v !== 32'h40)   begin n_fail++; $display("FAIL armov_pc got %h want 00000040", v); end
    commit(32'h14, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL rstpost_pre got %0d want 2", state); end
    rst = 1'b1; #1;
    n_checks += 3;
    if (state !== 2'd0)   begin n_fail++; $display("FAIL rstpost_state got %0d want 0", state); end
    if (count !== '0)     begin n_fail++; $display("FAIL rstpost_count got %0d want 0", count); end
    if (cyc_cnt !== '0)   begin n_fail++; $display("FAIL rstpost_cyc got %0d want 0", cyc_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_cyc_limit();
    logic [31:0] v;
    bit seen;
    trig_pc_en = 1'b0; post_cnt = '0; cyc_limit = 32'd1000;
    do_arm();
    commit(32'h80, 1'b0, 5'd0, 32'h0);
    commit(32'h84, 1'b0, 5'd0, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      @(posedge clk); #1;
      if (state == 2'd3) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL cyc_timeout got state %0d want 3 within 1200 cycles", state);
    end else begin
      n_checks += 4;
      if (cyc_cnt !== 32'd1001) begin n_fail++; $display("FAIL cyc_at_done got %0d want 1001", cyc_cnt); end
      if (halt_req !== 1'b1)    begin n_fail++; $display("FAIL cyc_halt got %b want 1", halt_req); end
      if (trig_idx !== 3'd1)    begin n_fail++; $display("FAIL cyc_trig_idx got %0d want 1", trig_idx); end
      if (count !== 4'd2)       begin n_fail++; $display("FAIL cyc_count got %0d want 2", count); end
    end
    for (int i = 0; i < 3; i++) commit(32'h200 + 32'(i * 4), 1'b0, 5'd0, 32'h0);
    read(3'd1, 2'd0, v);
    n_checks += 3;
    if (count !== 4'd2)  begin n_fail++; $display("FAIL cyc_frozen_count got %0d want 2", count); end
    if (v !== 32'h84)    begin n_fail++; $display("FAIL cyc_frozen_pc got %h want 00000084", v); end
    if (state !== 2'd3)  begin n_fail++; $display("FAIL cyc_frozen_state got %0d want 3", state); end
    cyc_limit = '0;
  endtask

  task automatic test_bounds();
    logic [31:0] v;
    commit(32'h300, 1'b1, 5'd0, 32'hFFFF_FFFF);
    rf_sel = 5'd0; #1; n_checks++;
    if (rf_data !== '0) begin n_fail++; $display("FAIL rf_x0 got %h want 0", rf_data); end
    read(3'd2, 2'd0, v); n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL rd_oob2 got %h want 0", v); end
    read(3'd7, 2'd3, v); n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL rd_oob7 got %h want 0", v); end
    cm_valid = 1'b1; cm_we = 1'b1; cm_rd = 5'd9; cm_wdata = 32'h5A5A; rf_sel = 5'd9; #1;
    n_checks++;
    if (rf_data !== '0) begin n_fail++; $display("FAIL rf_samecyc got %h want 0", rf_data); end
    @(posedge clk); #1;
    cm_valid = 1'b0; cm_we = 1'b0;
    n_checks++;
    if (rf_data !== 32'h5A5A) begin n_fail++; $display("FAIL rf_nextcyc got %h want 00005a5a", rf_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_wrap();
    test_pc_trigger();
    test_arm_override();
    test_cyc_limit();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
